mem_access_unit: RTL and testbench

Memory-interface stage on the LC-3 global bus, directly downstream of processing_unit.
- Captures addresses and store data driven onto the bus by the ALU/adder path into MAR/MDR.
- Runs a request/ready handshake with the memory model.
- Returns load data onto the bus, where it is written back through processing_unit's from_bus port.
- Sequenced by the control FSM via ld_mar, ld_mdr, mem_start and gate_mdr.

---
 rtl/mem_access_unit.sv | 81 ++++++++
 tb/tb_mem_access_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR capture from the global bus plus a request/ready memory handshake with timeout.
module mem_access_unit #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mem_start,
    input  logic              r_w,
    input  logic              gate_mdr,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] from_bus,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] to_bus,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t            state, state_nxt;
    logic [DATA_W-1:0] mar, mdr;
    logic [7:0]        cnt;
    logic              rw_q;
    logic              timeout_hit;

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        if (state == IDLE) begin
            state_nxt = mem_start ? REQ : IDLE;
        end else if (state == REQ) begin
            // a ready arriving on the last allowed cycle still completes normally
            timeout_hit = !mem_ready && cnt == 8'(TIMEOUT - 1);
            state_nxt   = (mem_ready || timeout_hit) ? DONE : REQ;
        end else begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            mar   <= '0;
            mdr   <= '0;
            cnt   <= '0;
            rw_q  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (ld_mar) mar <= from_bus;
                if (ld_mdr) mdr <= from_bus;
                if (mem_start) begin
                    rw_q <= r_w;
                    cnt  <= '0;
                end
            end
            if (state == REQ) begin
                if (mem_ready && !rw_q) mdr <= mem_rdata;
                if (!mem_ready) cnt <= cnt + 8'd1;
            end
            if (timeout_hit) err <= 1'b1;
            else if (clr_err) err <= 1'b0;
        end
    end

    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign mem_req   = state == REQ;
    assign busy      = state == REQ;
    assign mem_we    = state == REQ && rw_q;
    assign done      = state == DONE;
    assign to_bus    = gate_mdr ? mdr : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table plus hand sequences for timeout, ignored controls and async reset.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_mar, ld_mdr, mem_start, r_w, gate_mdr, clr_err, mem_ready;
    logic [15:0] from_bus, mem_rdata;
    logic [15:0] mem_addr, mem_wdata, to_bus;
    logic        mem_req, mem_we, busy, done, err;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        string       name;
        logic        ld_mar, ld_mdr, mem_start, r_w, gate_mdr, mem_ready;
        logic [15:0] from_bus, mem_rdata;
        logic [15:0] e_addr, e_wdata, e_to_bus;
        logic        e_req, e_we, e_busy, e_done, e_err;
    } vec_t;
    vec_t vq[$];

    mem_access_unit #(.DATA_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .reset(rst_n), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mem_start(mem_start),
        .r_w(r_w), .gate_mdr(gate_mdr), .clr_err(clr_err), .from_bus(from_bus),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we), .to_bus(to_bus),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        ld_mar = 0; ld_mdr = 0; mem_start = 0; r_w = 0; gate_mdr = 0; clr_err = 0;
        mem_ready = 0; from_bus = '0; mem_rdata = '0;
    endtask

    task automatic add(input string n, input logic lm, lmd, ms, rw, g, rdy,
                       input logic [15:0] fb, rd, ea, ew, et,
                       input logic rq, we, bz, dn, er);
        vec_t v;
        v.name = n; v.ld_mar = lm; v.ld_mdr = lmd; v.mem_start = ms; v.r_w = rw;
        v.gate_mdr = g; v.mem_ready = rdy; v.from_bus = fb; v.mem_rdata = rd;
        v.e_addr = ea; v.e_wdata = ew; v.e_to_bus = et;
        v.e_req = rq; v.e_we = we; v.e_busy = bz; v.e_done = dn; v.e_err = er;
        vq.push_back(v);
    endtask

    function automatic logic [63:0] outs();
        return {11'd0, mem_addr, mem_wdata, to_bus, mem_req, mem_we, busy, done, err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        idle_in();
        // lm lmd ms rw g rdy  from    rdata   addr    wdata   to_bus  rq we bz dn er
        add("rd_ld_mar",   1,0,0,0,0,0, 16'h3000,16'h0000, 16'h3000,16'h0000,16'h0000, 0,0,0,0,0);
        add("rd_start",    0,0,1,0,0,0, 16'h0000,16'h0000, 16'h3000,16'h0000,16'h0000, 1,0,1,0,0);
        add("rd_ready",    0,0,0,0,1,1, 16'h0000,16'hBEEF, 16'h3000,16'hBEEF,16'hBEEF, 0,0,0,1,0);
        add("rd_idle",     0,0,0,0,1,0, 16'h0000,16'h0000, 16'h3000,16'hBEEF,16'hBEEF, 0,0,0,0,0);
        add("ldstart",     1,0,1,0,0,0, 16'h1234,16'h0000, 16'h1234,16'hBEEF,16'h0000, 1,0,1,0,0);
        add("ldstart_rdy", 0,0,0,0,0,1, 16'h0000,16'h5A5A, 16'h1234,16'h5A5A,16'h0000, 0,0,0,1,0);
        add("ldstart_idle",0,0,0,0,0,0, 16'h0000,16'h0000, 16'h1234,16'h5A5A,16'h0000, 0,0,0,0,0);
        add("wr_ld_mar",   1,0,0,0,0,0, 16'h4001,16'h0000, 16'h4001,16'h5A5A,16'h0000, 0,0,0,0,0);
        add("wr_ld_mdr",   0,1,0,0,0,0, 16'h00A5,16'h0000, 16'h4001,16'h00A5,16'h0000, 0,0,0,0,0);
        add("wr_start",    0,0,1,1,0,0, 16'h0000,16'h0000, 16'h4001,16'h00A5,16'h0000, 1,1,1,0,0);
        add("wr_wait1",    0,0,0,0,0,0, 16'h0000,16'h0000, 16'h4001,16'h00A5,16'h0000, 1,1,1,0,0);
        add("wr_wait2",    0,0,0,0,0,0, 16'h0000,16'h0000, 16'h4001,16'h00A5,16'h0000, 1,1,1,0,0);
        add("wr_ready",    0,0,0,0,1,1, 16'h0000,16'hFFFF, 16'h4001,16'h00A5,16'h00A5, 0,0,0,1,0);
        add("rdy_in_idle", 0,0,0,0,1,1, 16'h0000,16'h1111, 16'h4001,16'h00A5,16'h00A5, 0,0,0,0,0);

        #12;
        chk("reset_outputs", outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            ld_mar = vq[i].ld_mar; ld_mdr = vq[i].ld_mdr; mem_start = vq[i].mem_start;
            r_w = vq[i].r_w; gate_mdr = vq[i].gate_mdr; mem_ready = vq[i].mem_ready;
            from_bus = vq[i].from_bus; mem_rdata = vq[i].mem_rdata;
            step();
            chk(vq[i].name, outs(), {11'd0, vq[i].e_addr, vq[i].e_wdata, vq[i].e_to_bus,
                vq[i].e_req, vq[i].e_we, vq[i].e_busy, vq[i].e_done, vq[i].e_err});
        end

        // timeout: ready never comes, TIMEOUT=4 gives exactly 4 request cycles
        @(negedge clk); idle_in(); mem_start = 1;
        step();
        @(negedge clk); idle_in();
        n = 0;
        for (int i = 0; i < 20 && mem_req; i++) begin
            n++;
            step();
        end
        chk("to_req_cycles", 64'(n), 64'd4);
        chk("to_done_err", {62'd0, done, err}, 64'b11);
        chk("to_mdr_kept", 64'(mem_wdata), 64'h00A5);
        @(negedge clk); clr_err = 1;
        step();
        chk("to_clr_err", {62'd0, done, err}, 64'b00);

        // controls during REQ ignored, mem_start in DONE ignored
        @(negedge clk); idle_in(); mem_start = 1;
        step();
        @(negedge clk); idle_in(); ld_mar = 1; from_bus = 16'hFFFF; mem_start = 1;
        step();
        chk("busy_ld_mar_ign", 64'(mem_addr), 64'h4001);
        chk("busy_still_req", {63'd0, mem_req}, 64'd1);
        @(negedge clk); idle_in(); mem_ready = 1; mem_rdata = 16'hC0DE;
        step();
        chk("busy_done", {62'd0, done, mem_req}, 64'b10);
        @(negedge clk); idle_in(); mem_start = 1;
        step();
        @(negedge clk); idle_in();
        step();
        chk("no_second_access", {61'd0, mem_req, busy, done}, 64'd0);
        chk("busy_rd_data", 64'(mem_wdata), 64'hC0DE);

        // clr_err held through a fresh timeout: set wins
        @(negedge clk); idle_in(); mem_start = 1;
        step();
        @(negedge clk); idle_in(); clr_err = 1;
        n = 0;
        for (int i = 0; i < 20 && mem_req; i++) begin
            n++;
            step();
        end
        chk("to2_req_cycles", 64'(n), 64'd4);
        chk("to2_set_wins", {63'd0, err}, 64'd1);

        // async reset mid-request
        @(negedge clk); idle_in(); ld_mar = 1; ld_mdr = 1; from_bus = 16'h2222;
        step();
        @(negedge clk); idle_in(); mem_start = 1; r_w = 1;
        step();
        chk("pre_reset_req", {61'd0, mem_req, mem_we, err}, 64'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", outs(), 64'd0);
        @(negedge clk); idle_in(); rst_n = 1'b1; mem_ready = 1; mem_rdata = 16'h7777;
        step();
        chk("late_ready_ign", outs(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
